// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: state
// encodings, opcode and function-field values, ALU operation codes and
// the ALUSrcB / PCSrc selector codes.
// No ports; imported by alu_dec and mc_ctrl_fsm.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if
// Bundle between the instruction register / datapath and the control unit.
// Parameters: ALUCTRL_W (ALUControl width), CNT_W (retire counter width).
// Modport master: the control unit (reads Op/Funct/MemReady, drives controls).
// Modport slave : the datapath side (drives Op/Funct/MemReady, reads controls).
interface mc_ctrl_fsm_if #(
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 16
);
    logic [5:0]           Op;
    logic [5:0]           Funct;
    logic                 MemReady;
    logic                 PCWrite;
    logic                 BranchEq;
    logic                 BranchNeq;
    logic                 IorD;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           PCSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 IllegalOp;
    logic                 Retire;
    logic [CNT_W-1:0]     RetireCnt;
    logic [3:0]           State;

    modport master (
        input  Op, Funct, MemReady,
        output PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
               ALUControl, IllegalOp, Retire, RetireCnt, State
    );

    modport slave (
        output Op, Funct, MemReady,
        input  PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
               ALUControl, IllegalOp, Retire, RetireCnt, State
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// alu_dec
// Combinational ALU operation decoder shared by the EXEC and IEXEC states.
// R-type instructions decode Funct; immediate instructions decode Op.
// Ports: op, funct (in, 6 each); alu_op (out, 3-bit ALU code);
//        valid (out, low when the instruction has no ALU mapping).
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    // An opcode of zero selects the function field; anything else is
    // treated as an immediate ALU opcode.
    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_NOR:  alu_op = ALU_NOR;
                default: valid  = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDI: alu_op = ALU_ADD;
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_SLTI: alu_op = ALU_SLT;
                default: valid  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
// Multicycle MIPS control unit: Moore FSM over FETCH/DECODE and the
// per-class execute states, with illegal-instruction flagging and a
// retired-instruction counter.
// Ports: CLK (rising edge), CLR (async active-high reset),
//        bus (mc_ctrl_fsm_if.master: Op/Funct/MemReady in, controls out).
// Optional feature macro: MEM_WAIT_EN -- FETCH, MEMRD and MEMWR stall
// until MemReady is high; without it MemReady is ignored.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    mc_ctrl_fsm_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             mem_ready;
    logic [2:0]       alu_op;
    logic             alu_valid;

`ifdef MEM_WAIT_EN
    assign mem_ready = bus.MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.MemReady;
    assign mem_ready        = 1'b1;
`endif

    alu_dec u_alu_dec (
        .op     (bus.Op),
        .funct  (bus.Funct),
        .alu_op (alu_op),
        .valid  (alu_valid)
    );

    // Next state and all control outputs. Everything is held at zero while
    // CLR is high so no strobe (not even the FETCH ones) leaks during reset.
    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.BranchEq   = 1'b0;
        bus.BranchNeq  = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = SRCB_REG;
        bus.PCSrc      = PCSRC_ALU;
        bus.ALUControl = ALUCTRL_W'(ALU_ADD);
        bus.IllegalOp  = 1'b0;
        if (!CLR) begin
            case (state_q)
                FETCH: begin
                    bus.IRWrite = mem_ready;
                    bus.PCWrite = mem_ready;
                    bus.ALUSrcB = SRCB_FOUR;
                    if (mem_ready) state_d = DECODE;
                end
                DECODE: begin
                    bus.ALUSrcB = SRCB_IMMSH;
                    case (bus.Op)
                        OP_LW, OP_SW:                     state_d = MEMADR;
                        OP_RTYPE:                         state_d = EXEC;
                        OP_BEQ, OP_BNE:                   state_d = BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
                        OP_J:                             state_d = JUMP;
                        default: begin
                            bus.IllegalOp = 1'b1;
                            state_d       = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    state_d     = (bus.Op == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    bus.IorD = 1'b1;
                    if (mem_ready) state_d = MEMWB;
                end
                MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                    retire       = 1'b1;
                    state_d      = FETCH;
                end
                MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                    retire       = mem_ready;
                    if (mem_ready) state_d = FETCH;
                end
                EXEC: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUControl = ALUCTRL_W'(alu_op);
                    if (alu_valid) begin
                        state_d = ALUWB;
                    end else begin
                        bus.IllegalOp = 1'b1;
                        state_d       = FETCH;
                    end
                end
                ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                    retire       = 1'b1;
                    state_d      = FETCH;
                end
                BRANCH: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUControl = ALUCTRL_W'(ALU_SUB);
                    bus.PCSrc      = PCSRC_ALUOUT;
                    bus.BranchEq   = (bus.Op == OP_BEQ);
                    bus.BranchNeq  = (bus.Op == OP_BNE);
                    retire         = 1'b1;
                    state_d        = FETCH;
                end
                IEXEC: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUSrcB    = SRCB_IMM;
                    bus.ALUControl = ALUCTRL_W'(alu_op);
                    state_d        = IWB;
                end
                IWB: begin
                    bus.RegWrite = 1'b1;
                    retire       = 1'b1;
                    state_d      = FETCH;
                end
                JUMP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = PCSRC_JUMP;
                    retire      = 1'b1;
                    state_d     = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign cnt_d         = cnt_q + CNT_W'(retire);
    assign bus.Retire    = retire;
    assign bus.RetireCnt = cnt_q;
    assign bus.State     = state_q;

    // State and retire counter; an asynchronous CLR aborts any instruction
    // in flight and returns to FETCH.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm
// Self-checking bench for mc_ctrl_fsm. Instructions are issued one at a
// time; for each cycle the expected controls are derived from the
// instruction class and queued, and a compare process checks the DUT on
// every falling edge. Built with ALUControl 4 bits wide and a 4-bit
// retire counter so zero-extension and wrap-around are visible.
// Honours MEM_WAIT_EN the same way the design does.
module tb_mc_ctrl_fsm;

    localparam int AW = 4;
    localparam int CW = 4;

`ifdef MEM_WAIT_EN
    localparam bit WAITS = 1'b1;
`else
    localparam bit WAITS = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ALUCTRL_W(AW), .CNT_W(CW)) bus ();

    mc_ctrl_fsm #(.ALUCTRL_W(AW), .CNT_W(CW)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]    st;
        logic          pcw, beq, bne, iord, mw, irw, rd, m2r, rw, asa;
        logic [1:0]    asb;
        logic [1:0]    pcs;
        logic [AW-1:0] alu;
        logic          ill, ret;
    } ctl_t;

    typedef struct {
        ctl_t          c;
        logic [CW-1:0] cnt;
        bit            alu_dc;
    } exp_t;

    exp_t          expq[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] model_cnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic ctl_t actual();
        ctl_t a;
        a.st   = bus.State;
        a.pcw  = bus.PCWrite;
        a.beq  = bus.BranchEq;
        a.bne  = bus.BranchNeq;
        a.iord = bus.IorD;
        a.mw   = bus.MemWrite;
        a.irw  = bus.IRWrite;
        a.rd   = bus.RegDst;
        a.m2r  = bus.MemtoReg;
        a.rw   = bus.RegWrite;
        a.asa  = bus.ALUSrcA;
        a.asb  = bus.ALUSrcB;
        a.pcs  = bus.PCSrc;
        a.alu  = bus.ALUControl;
        a.ill  = bus.IllegalOp;
        a.ret  = bus.Retire;
        return a;
    endfunction

    // Compare process: one queued expectation per clock cycle.
    initial begin
        exp_t e;
        ctl_t a;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = actual();
                if (e.alu_dc) begin
                    a.alu   = '0;
                    e.c.alu = '0;
                end
                checkOutput("controls", 32'(a), 32'(e.c));
                checkOutput("retire_cnt", 32'(bus.RetireCnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic ctl_t blank(input logic [3:0] st);
        ctl_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'h20:   return 3'd0;
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h2A:   return 3'd4;
            6'h27:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_op(input logic [5:0] o);
        case (o)
            6'h08:   return 3'd0;
            6'h0C:   return 3'd2;
            6'h0D:   return 3'd3;
            6'h0A:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input ctl_t c, input bit dc);
        exp_t e;
        e.c      = c;
        e.cnt    = model_cnt;
        e.alu_dc = dc;
        expq.push_back(e);
        if (c.ret) model_cnt = model_cnt + 1'b1;
    endtask

    // One clock cycle: drive inputs, queue the expectation, advance.
    task automatic cyc(input logic [5:0] op, input logic [5:0] funct, input logic rdy,
                       input ctl_t c, input bit dc);
        bus.Op       = op;
        bus.Funct    = funct;
        bus.MemReady = rdy;
        push(c, dc);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        clr       = 1'b1;
        model_cnt = '0;
        for (int i = 0; i < n; i++) begin
            bus.Op       = junk();
            bus.Funct    = junk();
            bus.MemReady = rnd();
            push(blank(4'd0), 1'b0);
            #3;
            checkOutput("reset_quiet",
                        {bus.RetireCnt, bus.State, bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite},
                        32'd0);
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
    endtask

    // kind: 0 R-type, 1 bad funct, 2 lw, 3 sw, 4 beq, 5 bne, 6 imm, 7 j, 8 bad op
    task automatic applyStimulus(input int kind, input logic [5:0] op, input logic [5:0] funct,
                                 input int wf, input int wm, input bit abort);
        ctl_t c;
        int   n;
        n = WAITS ? wf : 0;
        for (int i = 0; i < n; i++) begin
            c     = blank(4'd0);
            c.asb = 2'b01;
            cyc(junk(), junk(), 1'b0, c, 1'b0);
        end
        c     = blank(4'd0);
        c.asb = 2'b01;
        c.irw = 1'b1;
        c.pcw = 1'b1;
        cyc(junk(), junk(), WAITS ? 1'b1 : rnd(), c, 1'b0);

        c     = blank(4'd1);
        c.asb = 2'b11;
        c.ill = (kind == 8);
        cyc(op, funct, rnd(), c, 1'b0);

        n = WAITS ? wm : 0;
        case (kind)
            0: begin
                c     = blank(4'd6);
                c.asa = 1'b1;
                c.alu = AW'(alu_of_funct(funct));
                cyc(op, funct, rnd(), c, 1'b0);
                c     = blank(4'd7);
                c.rd  = 1'b1;
                c.rw  = 1'b1;
                c.ret = 1'b1;
                cyc(op, funct, rnd(), c, 1'b0);
            end
            1: begin
                c     = blank(4'd6);
                c.asa = 1'b1;
                c.ill = 1'b1;
                cyc(op, funct, rnd(), c, 1'b1);
            end
            2, 3: begin
                c     = blank(4'd2);
                c.asa = 1'b1;
                c.asb = 2'b10;
                cyc(op, funct, rnd(), c, 1'b0);
                if (kind == 2) begin
                    c      = blank(4'd3);
                    c.iord = 1'b1;
                    for (int i = 0; i < n; i++) cyc(op, funct, 1'b0, c, 1'b0);
                    cyc(op, funct, WAITS ? 1'b1 : rnd(), c, 1'b0);
                    c     = blank(4'd4);
                    c.m2r = 1'b1;
                    c.rw  = 1'b1;
                    c.ret = 1'b1;
                    cyc(op, funct, rnd(), c, 1'b0);
                end else begin
                    c      = blank(4'd5);
                    c.iord = 1'b1;
                    c.mw   = 1'b1;
                    for (int i = 0; i < n; i++) cyc(op, funct, 1'b0, c, 1'b0);
                    c.ret = 1'b1;
                    if (!abort) begin
                        cyc(op, funct, WAITS ? 1'b1 : rnd(), c, 1'b0);
                    end else begin
                        bus.Op       = op;
                        bus.Funct    = funct;
                        bus.MemReady = 1'b1;
                        push(c, 1'b0);
                        @(negedge clk);
                        #2;
                        clr = 1'b1;
                        #1;
                        checkOutput("abort_memwrite", 32'(bus.MemWrite), 32'd0);
                        checkOutput("abort_iord", 32'(bus.IorD), 32'd0);
                        checkOutput("abort_state", 32'(bus.State), 32'd0);
                        checkOutput("abort_cnt", 32'(bus.RetireCnt), 32'd0);
                        @(posedge clk);
                        #1;
                        doReset(2);
                    end
                end
            end
            4, 5: begin
                c     = blank(4'd8);
                c.asa = 1'b1;
                c.alu = AW'(1);
                c.pcs = 2'b01;
                c.beq = (kind == 4);
                c.bne = (kind == 5);
                c.ret = 1'b1;
                cyc(op, funct, rnd(), c, 1'b0);
            end
            6: begin
                c     = blank(4'd9);
                c.asa = 1'b1;
                c.asb = 2'b10;
                c.alu = AW'(alu_of_op(op));
                cyc(op, funct, rnd(), c, 1'b0);
                c     = blank(4'd10);
                c.rw  = 1'b1;
                c.ret = 1'b1;
                cyc(op, funct, rnd(), c, 1'b0);
            end
            7: begin
                c     = blank(4'd11);
                c.pcw = 1'b1;
                c.pcs = 2'b10;
                c.ret = 1'b1;
                cyc(op, funct, rnd(), c, 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic randomInstr();
        int         kind;
        logic [5:0] op;
        logic [5:0] funct;
        logic [5:0] goodF[6];
        logic [5:0] immOp[4];
        goodF = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        immOp = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
        kind  = $urandom_range(0, 8);
        funct = junk();
        case (kind)
            0: begin op = 6'h00; funct = goodF[$urandom_range(0, 5)]; end
            1: begin
                op = 6'h00;
                do funct = junk(); while (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
            end
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h05;
            6: op = immOp[$urandom_range(0, 3)];
            7: op = 6'h02;
            default: begin
                do op = junk();
                while (op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B});
            end
        endcase
        applyStimulus(kind, op, funct, $urandom_range(0, 2), $urandom_range(0, 2),
                      (kind == 3) && ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        clr          = 1'b1;
        bus.Op       = '0;
        bus.Funct    = '0;
        bus.MemReady = 1'b0;
        model_cnt    = '0;
        @(posedge clk);
        #1;
        doReset(3);

        bus.MemReady = 1'b1;
        #3;
        checkOutput("release_fetch", {bus.State, bus.IRWrite, bus.PCWrite, bus.ALUSrcB},
                    {4'd0, 1'b1, 1'b1, 2'b01});

        applyStimulus(0, 6'h00, 6'h20, 0, 0, 1'b0);
        checkOutput("add_retire_cnt", 32'(bus.RetireCnt), 32'd1);
        applyStimulus(8, 6'h3F, 6'h00, 0, 0, 1'b0);
        checkOutput("bad_op_cnt", 32'(bus.RetireCnt), 32'd1);
        applyStimulus(1, 6'h00, 6'h3F, 0, 0, 1'b0);
        checkOutput("bad_funct_cnt", 32'(bus.RetireCnt), 32'd1);
        applyStimulus(2, 6'h23, 6'h00, 2, 2, 1'b0);
        checkOutput("lw_cnt", 32'(bus.RetireCnt), 32'd2);
        applyStimulus(5, 6'h05, 6'h00, 0, 0, 1'b0);
        applyStimulus(4, 6'h04, 6'h00, 0, 0, 1'b0);
        applyStimulus(6, 6'h0D, 6'h00, 1, 0, 1'b0);
        checkOutput("imm_cnt", 32'(bus.RetireCnt), 32'd5);

        doReset(2);
        for (int i = 0; i < 17; i++) applyStimulus(7, 6'h02, junk(), 0, 0, 1'b0);
        checkOutput("jump_wrap_cnt", 32'(bus.RetireCnt), 32'd1);

        applyStimulus(3, 6'h2B, 6'h00, 0, 1, 1'b1);

        for (int i = 0; i < 400; i++) randomInstr();

        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle MIPS control unit. It is the parametrised successor of the current execute/write-back-only controller and covers the full instruction set: R-type ALU ops, immediate ALU ops, lw/sw, beq/bne and j. It sits between the instruction register (Op/Funct) and the datapath muxes, enables and memory strobes. It adds memory wait-state handshaking, illegal-instruction flagging and a retired-instruction counter.

## Interface
- ALUCTRL_W, 3, ALUControl width (≥3); encodings are zero-extended.
- CNT_W, 16, retired-instruction counter width.
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous, active-high reset.
- Op  in  6  instruction opcode.
- Funct  in  6  R-type function field.
- MemReady  in  1  memory access complete (used only with MEM_WAIT_EN).
- PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUControl  out  ALUCTRL_W  ADD 0, SUB 1, AND 2, OR 3, SLT 4, NOR 5.
- IllegalOp  out  1  one-cycle pulse on an undecodable instruction.
- Retire  out  1  one-cycle pulse on the final cycle of each completed instruction.
- RetireCnt  out  CNT_W  count of Retire pulses; wraps modulo 2^CNT_W.
- State  out  4  current state encoding, for debug.

## Operation
- Moore FSM. ALUControl additionally decodes Funct in EXEC and Op in IEXEC. Any control not listed for a state is 0.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ADD. Next state is DECODE.
- DECODE: ALUSrcB=11, ADD (branch target into ALUOut). Next state by opcode:
  - lw (23h) or sw (2Bh) → MEMADR
  - R-type (00h) → EXEC
  - beq (04h) or bne (05h) → BRANCH
  - addi (08h), andi (0Ch), ori (0Dh) or slti (0Ah) → IEXEC
  - j (02h) → JUMP
  - any other opcode → IllegalOp=1, then FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Next state is MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, Retire=1. Next state is FETCH.
- MEMWR: IorD=1, MemWrite=1, Retire=1. Next state is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. Funct decode: add 20h→ADD, sub 22h→SUB, and 24h→AND, or 25h→OR, slt 2Ah→SLT, nor 27h→NOR; next state ALUWB.
  - Any other Funct → IllegalOp=1, then FETCH; there is no write-back.
- ALUWB: RegDst=1, RegWrite=1, Retire=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, SUB, PCSrc=01, Retire=1. Assert BranchEq for beq, BranchNeq for bne. Next state is FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUControl from Op: addi→ADD, andi→AND, ori→OR, slti→SLT. Next state is IWB.
- IWB: RegWrite=1, RegDst=0, Retire=1. Next state is FETCH.
- JUMP: PCWrite=1, PCSrc=10, Retire=1. Next state is FETCH.
- Unused state encodings return to FETCH with all outputs 0.
- Op and Funct are sampled combinationally; they must be stable from DECODE until the instruction retires.

## Timing
- While CLR=1:
  - State=FETCH and RetireCnt=0.
  - All other outputs are forced to 0, including the FETCH strobes.
- The first FETCH strobes occur in the cycle after CLR deasserts.
- Asserting CLR mid-instruction aborts it immediately. No partial write-back or store occurs after the reset edge.
- Cycle counts with no wait states:
  - lw 5, sw 4, R-type 4, immediate 4, branch 3, jump 3.
  - Illegal opcode 2; illegal Funct 3.
- RetireCnt increments on the clock edge that ends a Retire cycle.
- IllegalOp and Retire are never high in the same cycle.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold their state until MemReady=1.
  - IorD and MemWrite stay asserted for the whole wait.
  - IRWrite and PCWrite (FETCH) and Retire (MEMWR) are asserted only in the cycle MemReady=1.
  - MEMRD advances on MemReady=1.
- MEM_WAIT_EN undefined: MemReady is ignored, every memory state lasts one cycle, and behaviour is identical to MemReady tied to 1.

## Structure
- Package mc_ctrl_pkg holds:
  - state localparams: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11
  - opcode and funct constants
  - ALU operation codes
  - ALUSrcB and PCSrc selector codes
- Sub-module alu_dec: combinational Op/Funct → ALUControl plus a valid flag, shared by EXEC and IEXEC.

## Test plan
- Reset: hold CLR=1 for 3 cycles → all outputs 0 and RetireCnt=0; release → FETCH with IRWrite=PCWrite=1 on the next cycle.
- add (Op 00h, Funct 20h) → states 0,1,6,7. EXEC shows ALUSrcA=1, ALUControl=0. ALUWB shows RegDst=RegWrite=1 and Retire=1; RetireCnt becomes 1.
- lw (Op 23h) with MEM_WAIT_EN and MemReady low for 2 cycles in both FETCH and MEMRD:
  - each of these states is held 3 cycles
  - IRWrite pulses once
  - lw completes in 9 cycles and MEMWB asserts MemtoReg=RegWrite=1
- bne (Op 05h) → BRANCH with BranchNeq=1, BranchEq=0, ALUControl=SUB, PCSrc=01. beq asserts BranchEq only.
- Illegal opcode 3Fh → IllegalOp pulse in DECODE, return to FETCH, RetireCnt unchanged. R-type Funct 3Fh → IllegalOp in EXEC, RegWrite never asserted.
- With CNT_W=4, retire 17 j instructions (Op 02h) → RetireCnt=1 after wrap. JUMP shows PCSrc=10 and PCWrite=1. CLR asserted in MEMWR → MemWrite drops at once.
